// File: rtl/exec_seq_pkg.sv
// Shared encodings and default latencies for the multi-cycle execute sequencer.
package exec_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        KIND_DIV = 1'b0,
        KIND_FPU = 1'b1
    } kind_e;

    localparam int DEFAULT_DIV_LAT = 32;
    localparam int DEFAULT_FPU_LAT = 4;
    localparam int DEFAULT_CNT_W   = 6;

    // A latency is usable if it lies in 2..63 and fits the counter width.
    function automatic bit lat_legal(input int lat, input int cnt_w);
        return (lat >= 2) && (lat <= 63) && (lat <= (2 ** cnt_w) - 1);
    endfunction

endpackage

// File: rtl/exec_seq_latcnt.sv
// Loadable down-counter that tracks the remaining cycles of a multi-cycle operation.
module exec_seq_latcnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/exec_seq_ctrl.sv
// Issue/stall/writeback sequencer for the iterative divider and multi-cycle FPU path.
// Define EARLY_DONE_EN to let unit_done_i end a BUSY phase before the counter expires.
module exec_seq_ctrl
    import exec_seq_pkg::*;
#(
    parameter int DIV_LAT = DEFAULT_DIV_LAT,
    parameter int FPU_LAT = DEFAULT_FPU_LAT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid_i,
    input  logic       issue_kind_i,
    input  logic [4:0] issue_rd_i,
    input  logic       issue_fpr_i,
    input  logic       flush_i,
    input  logic       unit_done_i,
    output logic       unit_start_o,
    output logic       unit_kind_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic       wb_valid_o,
    output logic [4:0] wb_rd_o,
    output logic       wb_fpr_o,
    output logic       abort_o
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] FPU_LOAD = CNT_W'(FPU_LAT - 1);

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [4:0]       rd_q, rd_d;
    logic             fpr_q, fpr_d;
    logic             cnt_load, cnt_dec, cnt_is_one;
    logic [CNT_W-1:0] cnt_load_val;
    logic             early_done;

`ifdef EARLY_DONE_EN
    assign early_done = unit_done_i;
`else
    logic unused_unit_done;
    assign unused_unit_done = unit_done_i;
    assign early_done       = 1'b0;
`endif

    exec_seq_latcnt #(
        .CNT_W(CNT_W)
    ) u_latcnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (cnt_dec),
        .is_one_o  (cnt_is_one)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        rd_d         = rd_q;
        fpr_d        = fpr_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unit_start_o = 1'b0;
        stall_o      = 1'b0;
        wb_valid_o   = 1'b0;
        abort_o      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Gated by rst so the strobe stays low while reset is held.
                if (rst && issue_valid_i && !flush_i) begin
                    unit_start_o = 1'b1;
                    stall_o      = 1'b1;
                    kind_d       = kind_e'(issue_kind_i);
                    rd_d         = issue_rd_i;
                    fpr_d        = issue_fpr_i;
                    cnt_load     = 1'b1;
                    cnt_load_val = issue_kind_i ? FPU_LOAD : DIV_LOAD;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    abort_o = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_is_one || early_done) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // issue_valid_i still belongs to the completing instruction here.
                if (flush_i) begin
                    abort_o = 1'b1;
                end else begin
                    wb_valid_o = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_DIV;
            rd_q    <= '0;
            fpr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            rd_q    <= rd_d;
            fpr_q   <= fpr_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign unit_kind_o = kind_q;
    assign wb_rd_o     = rd_q;
    assign wb_fpr_o    = fpr_q;

`ifndef SYNTHESIS
    lat_legal_a: assert property (@(posedge clk) disable iff (!rst)
        lat_legal(DIV_LAT, CNT_W) && lat_legal(FPU_LAT, CNT_W))
        else $error("exec_seq_ctrl: latency parameter outside 2..63 or wider than CNT_W");
`endif

endmodule
